// File: rtl/bloom_filter_pkg.sv
// Shared constants and types for the bloom filter match path: record layout,
// match vector geometry and the reporter's serializer states.
package bloom_filter_pkg;

  localparam int PER_STRING_FIFO_DEPTH = 4;
  localparam int AST_SINK_SYMBOLS      = 8;
  localparam int MIN_STR_SIZE          = 4;
  localparam int MAX_STR_SIZE          = 20;
  localparam int MATCH_CNT_CNT         = (MAX_STR_SIZE - MIN_STR_SIZE + 1) * AST_SINK_SYMBOLS;
  localparam int MATCH_REC_W           = 48;

  typedef struct packed {
    logic [31:0] word_num;
    logic [7:0]  str_len;
    logic [7:0]  lane;
  } match_rec_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } ser_state_e;

endpackage

// File: rtl/bloom_match_fifo.sv
// Single-clock show-ahead FIFO: data_o always presents the head entry, and a
// push into a full FIFO is accepted when a pop happens in the same cycle.
module bloom_match_fifo #(
  parameter int WIDTH = 168,
  parameter int DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("bloom_match_fifo: DEPTH must be a power of 2 and at least 2");
  end

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             do_push, do_pop;

  // The extra pointer bit distinguishes full from empty when the indices match.
  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // NOTE: storage is left unreset; the pointers alone define what is valid,
  // and resetting a RAM array would prevent it mapping to memory primitives.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end

endmodule

// File: rtl/bloom_match_reporter.sv
// Buffers nonzero match vectors tagged with their word number and serializes
// each one, lowest bit first, into 48-bit Avalon-ST records framed by SOP/EOP.
module bloom_match_reporter
  import bloom_filter_pkg::*;
#(
  parameter int FIFO_DEPTH = PER_STRING_FIFO_DEPTH,
  parameter int MATCH_W    = MATCH_CNT_CNT
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  input  logic                   en_i,
  input  logic                   match_valid_i,
  input  logic [MATCH_W-1:0]     match_i,
  input  logic                   ast_source_ready_i,
  output logic                   ast_source_valid_o,
  output logic [MATCH_REC_W-1:0] ast_source_data_o,
  output logic                   ast_source_startofpacket_o,
  output logic                   ast_source_endofpacket_o,
  output logic [31:0]            drop_cnt_o
);

  localparam int FIFO_W = MATCH_W + 32;

  function automatic logic [7:0] lowest_set(input logic [MATCH_W-1:0] v);
    logic [7:0] idx;
    idx = '0;
    for (int i = MATCH_W - 1; i >= 0; i--) begin
      if (v[i]) idx = 8'(i);
    end
    return idx;
  endfunction

  function automatic match_rec_t idx_to_rec(input logic [31:0] word, input logic [7:0] idx);
    match_rec_t r;
    r.word_num = word;
    r.str_len  = 8'(MIN_STR_SIZE) + idx / 8'(AST_SINK_SYMBOLS);
    r.lane     = idx % 8'(AST_SINK_SYMBOLS);
    return r;
  endfunction

  ser_state_e         state_q, state_d;
  logic [MATCH_W-1:0] work_q, work_d;
  match_rec_t         rec_q, rec_d;
  logic               sop_q, sop_d;
  logic               eop_q, eop_d;
  logic [31:0]        word_cnt_q, word_cnt_d;
  logic [31:0]        drop_cnt_q, drop_cnt_d;
  logic [31:0]        next_word;

  logic               push_req, drop;
  logic               load, pop;
  logic [FIFO_W-1:0]  fifo_head;
  logic               fifo_full, fifo_empty;

  assign push_req = en_i && match_valid_i && (|match_i);

  bloom_match_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .push_i  (push_req),
    .data_i  ({word_cnt_q, match_i}),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // NOTE: combinational blocks use blocking assignments and give every
  // output a default first, so no path leaves a variable unassigned (latch).
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    sop_d   = sop_q;
    load    = 1'b0;

    if (state_q == ST_IDLE) begin
      load = !fifo_empty;
    end else if (ast_source_ready_i) begin
      sop_d = 1'b0;
      if (eop_q) begin
        // Last record of this vector: chain straight into the next one.
        if (!fifo_empty) begin
          load = 1'b1;
        end else begin
          state_d = ST_IDLE;
          work_d  = '0;
        end
      end else begin
        work_d = work_q & (work_q - MATCH_W'(1));
      end
    end

    next_word = rec_q.word_num;
    if (load) begin
      state_d   = ST_SEND;
      work_d    = fifo_head[MATCH_W-1:0];
      next_word = fifo_head[FIFO_W-1:MATCH_W];
      sop_d     = 1'b1;
    end
    pop = load;

    if (state_d == ST_SEND) begin
      rec_d = idx_to_rec(next_word, lowest_set(work_d));
      eop_d = ((work_d & (work_d - MATCH_W'(1))) == '0);
    end else begin
      rec_d = '0;
      eop_d = 1'b0;
      sop_d = 1'b0;
    end
  end

  always_comb begin
    word_cnt_d = word_cnt_q;
    drop_cnt_d = drop_cnt_q;
    drop       = push_req && fifo_full && !pop;
    if (en_i && match_valid_i) word_cnt_d = word_cnt_q + 32'd1;
    if (drop && drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + 32'd1;
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= ST_IDLE;
      work_q     <= '0;
      rec_q      <= '0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      word_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      work_q     <= work_d;
      rec_q      <= rec_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      word_cnt_q <= word_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign ast_source_valid_o         = (state_q == ST_SEND);
  assign ast_source_data_o          = rec_q;
  assign ast_source_startofpacket_o = sop_q;
  assign ast_source_endofpacket_o   = eop_q;
  assign drop_cnt_o                 = drop_cnt_q;

endmodule

// File: tb/tb_bloom_match_reporter.sv
// Directed bench for bloom_match_reporter: single hit, backpressure, overflow,
// full-with-pop, enable gating, counter wrap and reset mid-packet.
module tb_bloom_match_reporter;

  localparam int MW = 136;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic          en_i;
  logic          match_valid_i;
  logic [MW-1:0] match_i;
  logic          ast_source_ready_i;
  logic          ast_source_valid_o;
  logic [47:0]   ast_source_data_o;
  logic          ast_source_startofpacket_o;
  logic          ast_source_endofpacket_o;
  logic [31:0]   drop_cnt_o;

  int checks   = 0;
  int failures = 0;

  bloom_match_reporter dut (
    .clk_i                      (clk_i),
    .rst_n_i                    (rst_n_i),
    .en_i                       (en_i),
    .match_valid_i              (match_valid_i),
    .match_i                    (match_i),
    .ast_source_ready_i         (ast_source_ready_i),
    .ast_source_valid_o         (ast_source_valid_o),
    .ast_source_data_o          (ast_source_data_o),
    .ast_source_startofpacket_o (ast_source_startofpacket_o),
    .ast_source_endofpacket_o   (ast_source_endofpacket_o),
    .drop_cnt_o                 (drop_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic logic [MW-1:0] onehot(input int i);
    logic [MW-1:0] r;
    r    = '0;
    r[i] = 1'b1;
    return r;
  endfunction

  function automatic logic [47:0] exp_rec(input logic [31:0] w, input logic [7:0] len,
                                          input logic [7:0] lane);
    return {w, len, lane};
  endfunction

  // Drives one beat for one clock edge; returns just after the following negedge.
  task automatic beat(input logic [MW-1:0] m);
    en_i          = 1'b1;
    match_valid_i = 1'b1;
    match_i       = m;
    @(negedge clk_i);
    match_valid_i = 1'b0;
    match_i       = '0;
  endtask

  // Captures the record visible now (or the next one, within a bound) and
  // advances one cycle; waited is -1 on timeout.
  task automatic wait_rec(output logic [47:0] d, output logic s, output logic e,
                          output int waited);
    waited = 0;
    d = '0; s = 1'b0; e = 1'b0;
    while (!ast_source_valid_o && waited < 40) begin
      @(negedge clk_i);
      waited++;
    end
    if (ast_source_valid_o) begin
      d = ast_source_data_o;
      s = ast_source_startofpacket_o;
      e = ast_source_endofpacket_o;
      @(negedge clk_i);
    end else begin
      waited = -1;
    end
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0; en_i = 1'b0; match_valid_i = 1'b0; match_i = '0;
    ast_source_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    checks++;
    if (ast_source_valid_o !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%b exp=0", ast_source_valid_o);
    end
    checks++;
    if (ast_source_data_o !== 48'd0) begin
      failures++; $display("FAIL reset_data got=%h exp=0", ast_source_data_o);
    end
    checks++;
    if ({ast_source_startofpacket_o, ast_source_endofpacket_o} !== 2'b00) begin
      failures++; $display("FAIL reset_sop_eop got=%b%b exp=00",
                           ast_source_startofpacket_o, ast_source_endofpacket_o);
    end
    checks++;
    if (drop_cnt_o !== 32'd0) begin
      failures++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt_o);
    end
    rst_n_i = 1'b1;
  endtask

  task automatic test_single_hit();
    en_i = 1'b1; ast_source_ready_i = 1'b1;
    beat('0);
    beat(onehot(9));
    checks++;
    if (ast_source_valid_o !== 1'b0) begin
      failures++; $display("FAIL single_early_valid got=%b exp=0", ast_source_valid_o);
    end
    @(negedge clk_i);
    checks++;
    if (ast_source_valid_o !== 1'b1) begin
      failures++; $display("FAIL single_valid got=%b exp=1", ast_source_valid_o);
    end
    checks++;
    if (ast_source_data_o !== exp_rec(32'd1, 8'd5, 8'd1)) begin
      failures++; $display("FAIL single_data got=%h exp=%h", ast_source_data_o,
                           exp_rec(32'd1, 8'd5, 8'd1));
    end
    checks++;
    if ({ast_source_startofpacket_o, ast_source_endofpacket_o} !== 2'b11) begin
      failures++; $display("FAIL single_sop_eop got=%b%b exp=11",
                           ast_source_startofpacket_o, ast_source_endofpacket_o);
    end
    @(negedge clk_i);
    checks++;
    if (ast_source_valid_o !== 1'b0) begin
      failures++; $display("FAIL single_after got=%b exp=0", ast_source_valid_o);
    end
  endtask

  task automatic test_multi_backpressure();
    logic [47:0] exp_d [3];
    logic [MW-1:0] v;
    exp_d[0] = exp_rec(32'd2, 8'd4, 8'd0);
    exp_d[1] = exp_rec(32'd2, 8'd5, 8'd0);
    exp_d[2] = exp_rec(32'd2, 8'd20, 8'd7);
    v = onehot(0) | onehot(8) | onehot(135);
    ast_source_ready_i = 1'b0;
    beat(v);
    @(negedge clk_i);
    for (int k = 0; k < 3; k++) begin
      for (int hold = 0; hold < 2; hold++) begin
        checks++;
        if ({ast_source_valid_o, ast_source_data_o, ast_source_startofpacket_o,
             ast_source_endofpacket_o} !== {1'b1, exp_d[k], k == 0, k == 2}) begin
          failures++;
          $display("FAIL multi_rec%0d_hold%0d got=%b/%h/%b%b exp=1/%h/%b%b", k, hold,
                   ast_source_valid_o, ast_source_data_o, ast_source_startofpacket_o,
                   ast_source_endofpacket_o, exp_d[k], k == 0, k == 2);
        end
        if (hold == 0) @(negedge clk_i);
      end
      ast_source_ready_i = 1'b1;
      @(negedge clk_i);
      ast_source_ready_i = 1'b0;
    end
    checks++;
    if (ast_source_valid_o !== 1'b0) begin
      failures++; $display("FAIL multi_end_valid got=%b exp=0", ast_source_valid_o);
    end
  endtask

  task automatic test_overflow();
    logic [47:0] d;
    logic s, e;
    int w;
    ast_source_ready_i = 1'b0;
    for (int i = 0; i < 6; i++) beat(onehot(i));
    checks++;
    if (drop_cnt_o !== 32'd1) begin
      failures++; $display("FAIL overflow_drop got=%0d exp=1", drop_cnt_o);
    end
    ast_source_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_rec(d, s, e, w);
      checks++;
      if ({d, s, e} !== {exp_rec(32'(3 + i), 8'd4, 8'(i)), 2'b11} || w != 0) begin
        failures++; $display("FAIL overflow_pkt%0d got=%h/%b%b wait=%0d exp=%h/11 wait=0",
                             i, d, s, e, w, exp_rec(32'(3 + i), 8'd4, 8'(i)));
      end
    end
    checks++;
    if (ast_source_valid_o !== 1'b0) begin
      failures++; $display("FAIL overflow_extra got=%b exp=0", ast_source_valid_o);
    end
  endtask

  task automatic test_full_same_cycle_pop();
    logic [47:0] d;
    logic s, e;
    int w;
    logic [7:0] lanes [6];
    lanes = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd7};
    ast_source_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) beat(onehot(i));
    ast_source_ready_i = 1'b1;
    en_i = 1'b1; match_valid_i = 1'b1; match_i = onehot(7);
    for (int i = 0; i < 6; i++) begin
      wait_rec(d, s, e, w);
      match_valid_i = 1'b0; match_i = '0;
      checks++;
      if ({d, s, e} !== {exp_rec(32'(9 + i), 8'd4, lanes[i]), 2'b11} || w != 0) begin
        failures++; $display("FAIL fullpop_pkt%0d got=%h/%b%b wait=%0d exp=%h/11 wait=0",
                             i, d, s, e, w, exp_rec(32'(9 + i), 8'd4, lanes[i]));
      end
    end
    checks++;
    if (drop_cnt_o !== 32'd1) begin
      failures++; $display("FAIL fullpop_drop got=%0d exp=1", drop_cnt_o);
    end
  endtask

  task automatic test_gating_wrap();
    logic [47:0] d;
    logic s, e;
    int w;
    ast_source_ready_i = 1'b1;
    en_i = 1'b0; match_valid_i = 1'b1; match_i = '1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checks++;
      if (ast_source_valid_o !== 1'b0) begin
        failures++; $display("FAIL gated_valid%0d got=%b exp=0", i, ast_source_valid_o);
      end
    end
    match_valid_i = 1'b0; match_i = '0;
    beat(onehot(2));
    wait_rec(d, s, e, w);
    checks++;
    if (d !== exp_rec(32'd15, 8'd4, 8'd2) || w < 0) begin
      failures++; $display("FAIL gated_hold_tag got=%h wait=%0d exp=%h", d, w,
                           exp_rec(32'd15, 8'd4, 8'd2));
    end
    force dut.word_cnt_d = 32'hFFFF_FFFF;
    @(negedge clk_i);
    release dut.word_cnt_d;
    beat(onehot(0));
    beat(onehot(8));
    wait_rec(d, s, e, w);
    checks++;
    if (d !== exp_rec(32'hFFFF_FFFF, 8'd4, 8'd0) || w < 0) begin
      failures++; $display("FAIL wrap_tag_max got=%h wait=%0d exp=%h", d, w,
                           exp_rec(32'hFFFF_FFFF, 8'd4, 8'd0));
    end
    wait_rec(d, s, e, w);
    checks++;
    if (d !== exp_rec(32'd0, 8'd5, 8'd0) || w != 0) begin
      failures++; $display("FAIL wrap_tag_zero got=%h wait=%0d exp=%h", d, w,
                           exp_rec(32'd0, 8'd5, 8'd0));
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [47:0] d;
    logic s, e;
    int w;
    ast_source_ready_i = 1'b0;
    beat(onehot(0) | onehot(1) | onehot(2));
    @(negedge clk_i);
    ast_source_ready_i = 1'b1;
    @(negedge clk_i);
    ast_source_ready_i = 1'b0;
    checks++;
    if ({ast_source_valid_o, ast_source_data_o, ast_source_startofpacket_o,
         ast_source_endofpacket_o} !== {1'b1, exp_rec(32'd1, 8'd4, 8'd1), 2'b00}) begin
      failures++; $display("FAIL midrst_second got=%b/%h exp=1/%h", ast_source_valid_o,
                           ast_source_data_o, exp_rec(32'd1, 8'd4, 8'd1));
    end
    #2 rst_n_i = 1'b0;
    #1;
    checks++;
    if ({ast_source_valid_o, ast_source_endofpacket_o, drop_cnt_o} !== {2'b00, 32'd0}) begin
      failures++; $display("FAIL midrst_clear got=%b/%b/%0d exp=0/0/0", ast_source_valid_o,
                           ast_source_endofpacket_o, drop_cnt_o);
    end
    @(negedge clk_i);
    rst_n_i = 1'b1;
    ast_source_ready_i = 1'b1;
    beat(onehot(3));
    wait_rec(d, s, e, w);
    checks++;
    if ({d, s, e} !== {exp_rec(32'd0, 8'd4, 8'd3), 2'b11} || w < 0) begin
      failures++; $display("FAIL midrst_next_tag got=%h/%b%b wait=%0d exp=%h/11", d, s, e, w,
                           exp_rec(32'd0, 8'd4, 8'd3));
    end
    checks++;
    if (ast_source_valid_o !== 1'b0) begin
      failures++; $display("FAIL midrst_idle got=%b exp=0", ast_source_valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_multi_backpressure();
    test_overflow();
    test_full_same_cycle_pop();
    test_gating_wrap();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
